// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - parametrised universal shift register with word snapshot
//
// Purpose:
//   WIDTH-bit register that holds, shifts right, shifts left or parallel-loads,
//   moving LANE_W bits per enabled shift. Every N = WIDTH/LANE_W enabled shifts
//   complete one word. The post-shift value of that word is captured in word_q,
//   and word_valid pulses for one cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   en         in   shift/load enable (hold when low)
//   sclr       in   synchronous clear, overrides en
//   mode       in   00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin_r      in   LANE_W lane entering at the MSB end on a right shift
//   sin_l      in   LANE_W lane entering at the LSB end on a left shift
//   pin        in   WIDTH parallel load data
//   q          out  register contents
//   sout_r     out  lane leaving on a right shift (q LSB lane)
//   sout_l     out  lane leaving on a left shift (q MSB lane)
//   cnt        out  lanes shifted in for the current word
//   word_q     out  snapshot of the last completed word
//   word_valid out  one-cycle strobe for a new word_q

module univ_shift_reg #(
    parameter int  WIDTH  = 8,
    parameter int  LANE_W = 1,
    localparam int CNT_W  = ((WIDTH / LANE_W) > 1) ? $clog2(WIDTH / LANE_W) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              sclr,
    input  logic [1:0]        mode,
    input  logic [LANE_W-1:0] sin_r,
    input  logic [LANE_W-1:0] sin_l,
    input  logic [WIDTH-1:0]  pin,
    output logic [WIDTH-1:0]  q,
    output logic [LANE_W-1:0] sout_r,
    output logic [LANE_W-1:0] sout_l,
    output logic [CNT_W-1:0]  cnt,
    output logic [WIDTH-1:0]  word_q,
    output logic              word_valid
);

    localparam int               N        = WIDTH / LANE_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_word_q;
    logic             r_word_valid;
    logic [WIDTH-1:0] w_shift;

    // Next value for either shift direction; mode[0] selects right (01) vs left (10).
    // With a single lane per word the whole register is replaced by the input lane,
    // which also avoids the empty slice of the general form.
    generate
        if (N == 1) begin : g_single_lane
            always_comb begin
                w_shift = mode[0] ? sin_r : sin_l;
            end
        end else begin : g_multi_lane
            always_comb begin
                w_shift = mode[0] ? {sin_r, r_q[WIDTH-1:LANE_W]}
                                  : {r_q[WIDTH-LANE_W-1:0], sin_l};
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q          <= '0;
            r_cnt        <= '0;
            r_word_q     <= '0;
            r_word_valid <= 1'b0;
        end else begin
            // Strobe is low unless this edge completes a word.
            r_word_valid <= 1'b0;
            if (sclr) begin
                r_q   <= '0;
                r_cnt <= '0;
            end else if (en) begin
                case (mode)
                    MODE_RIGHT, MODE_LEFT: begin
                        r_q <= w_shift;
                        // Lanes are counted regardless of direction.
                        if (r_cnt == CNT_LAST) begin
                            r_cnt        <= '0;
                            r_word_q     <= w_shift;
                            r_word_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    MODE_LOAD: begin
                        r_q   <= pin;
                        r_cnt <= '0;
                    end
                    MODE_HOLD: begin
                        r_q <= r_q;
                    end
                    default: begin
                        r_q <= r_q;
                    end
                endcase
            end
        end
    end

    assign q          = r_q;
    assign sout_r     = r_q[LANE_W-1:0];
    assign sout_l     = r_q[WIDTH-1 -: LANE_W];
    assign cnt        = r_cnt;
    assign word_q     = r_word_q;
    assign word_valid = r_word_valid;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard testbench for univ_shift_reg
module tb_univ_shift_reg;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: WIDTH=8, LANE_W=1
    logic       en0 = 0, sclr0 = 0, sinr0 = 0, sinl0 = 0;
    logic [1:0] mode0 = 0;
    logic [7:0] pin0 = 0;
    logic [7:0] q0, wq0;
    logic       sor0, sol0, wv0;
    logic [2:0] cnt0;

    // DUT 1: WIDTH=8, LANE_W=4
    logic       en1 = 0, sclr1 = 0;
    logic [1:0] mode1 = 0;
    logic [3:0] sinr1 = 0, sinl1 = 0;
    logic [7:0] pin1 = 0;
    logic [7:0] q1, wq1;
    logic [3:0] sor1, sol1;
    logic       wv1;
    logic [0:0] cnt1;

    univ_shift_reg #(.WIDTH(8), .LANE_W(1)) u0 (
        .clk(clk), .reset_n(reset_n), .en(en0), .sclr(sclr0), .mode(mode0),
        .sin_r(sinr0), .sin_l(sinl0), .pin(pin0), .q(q0), .sout_r(sor0),
        .sout_l(sol0), .cnt(cnt0), .word_q(wq0), .word_valid(wv0)
    );

    univ_shift_reg #(.WIDTH(8), .LANE_W(4)) u1 (
        .clk(clk), .reset_n(reset_n), .en(en1), .sclr(sclr1), .mode(mode1),
        .sin_r(sinr1), .sin_l(sinl1), .pin(pin1), .q(q1), .sout_r(sor1),
        .sout_l(sol1), .cnt(cnt1), .word_q(wq1), .word_valid(wv1)
    );

    typedef struct {
        string      name;
        int         dut;
        logic [7:0] q;
        int         cnt;
        logic [7:0] wq;
        logic       wv;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: outputs are stable at the falling edge; drain everything pushed since.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.dut == 0) begin
                chk({e.name, ".q"},      32'(q0),   32'(e.q));
                chk({e.name, ".cnt"},    32'(cnt0), 32'(e.cnt));
                chk({e.name, ".word_q"}, 32'(wq0),  32'(e.wq));
                chk({e.name, ".wv"},     32'(wv0),  32'(e.wv));
                chk({e.name, ".sout_r"}, 32'(sor0), 32'(e.q[0]));
                chk({e.name, ".sout_l"}, 32'(sol0), 32'(e.q[7]));
            end else begin
                chk({e.name, ".q"},      32'(q1),   32'(e.q));
                chk({e.name, ".cnt"},    32'(cnt1), 32'(e.cnt));
                chk({e.name, ".word_q"}, 32'(wq1),  32'(e.wq));
                chk({e.name, ".wv"},     32'(wv1),  32'(e.wv));
                chk({e.name, ".sout_r"}, 32'(sor1), 32'(e.q[3:0]));
                chk({e.name, ".sout_l"}, 32'(sol1), 32'(e.q[7:4]));
            end
        end
    end

    task automatic expect0(input string nm, input logic [7:0] q, input int c,
                           input logic [7:0] wq, input logic wv);
        exp_t e;
        e.name = nm; e.dut = 0; e.q = q; e.cnt = c; e.wq = wq; e.wv = wv;
        sb.push_back(e);
    endtask

    task automatic expect1(input string nm, input logic [7:0] q, input int c,
                           input logic [7:0] wq, input logic wv);
        exp_t e;
        e.name = nm; e.dut = 1; e.q = q; e.cnt = c; e.wq = wq; e.wv = wv;
        sb.push_back(e);
    endtask

    // Drive one command to DUT 0 for one rising edge, then return its inputs to idle.
    task automatic step0(input logic s, input logic e, input logic [1:0] m,
                         input logic sr, input logic sl, input logic [7:0] p);
        @(negedge clk); #1;
        sclr0 = s; en0 = e; mode0 = m; sinr0 = sr; sinl0 = sl; pin0 = p;
        @(posedge clk); #1;
        sclr0 = 0; en0 = 0;
    endtask

    task automatic step1(input logic e, input logic [1:0] m, input logic [3:0] sr);
        @(negedge clk); #1;
        sclr1 = 0; en1 = e; mode1 = m; sinr1 = sr;
        @(posedge clk); #1;
        en1 = 0;
    endtask

    logic [7:0] rq [8];
    logic [7:0] lq [4];
    logic [7:0] mq [8];
    logic [7:0] seq_r;

    initial begin
        rq = '{8'h80, 8'h40, 8'hA0, 8'hD0, 8'h68, 8'h34, 8'h9A, 8'h4D};
        lq = '{8'h01, 8'h03, 8'h06, 8'h0D};
        mq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        seq_r = 8'b0100_1101;   // sin_r sequence 1,0,1,1,0,0,1,0 read from bit 0 upward

        // Power-on reset
        @(posedge clk); #2;
        expect0("por0", 8'h00, 0, 8'h00, 1'b0);
        expect1("por1", 8'h00, 0, 8'h00, 1'b0);
        @(negedge clk); #1 reset_n = 1'b1;

        // 1. Three shifts, then an asynchronous reset pulse between edges
        step0(0, 1, 2'b01, 1, 0, 0); expect0("t1_s1", 8'h80, 1, 8'h00, 0);
        step0(0, 1, 2'b01, 1, 0, 0); expect0("t1_s2", 8'hC0, 2, 8'h00, 0);
        step0(0, 1, 2'b01, 1, 0, 0); expect0("t1_s3", 8'hE0, 3, 8'h00, 0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1 expect0("t1_async_rst", 8'h00, 0, 8'h00, 0);
        @(negedge clk); #1 reset_n = 1'b1;

        // 2. Shift right a full word
        for (int i = 0; i < 8; i++) begin
            step0(0, 1, 2'b01, seq_r[i], 0, 0);
            expect0($sformatf("t2_r%0d", i + 1), rq[i], (i + 1) % 8,
                    (i == 7) ? 8'h4D : 8'h00, i == 7);
        end
        step0(0, 0, 2'b00, 0, 0, 0); expect0("t2_strobe_drop", 8'h4D, 0, 8'h4D, 0);

        // 3. Clear, then shift left
        step0(1, 0, 2'b00, 0, 0, 0); expect0("t3_sclr", 8'h00, 0, 8'h4D, 0);
        for (int i = 0; i < 4; i++) begin
            step0(0, 1, 2'b10, 0, (i != 2), 0);
            expect0($sformatf("t3_l%0d", i + 1), lq[i], i + 1, 8'h4D, 0);
        end
        step0(0, 1, 2'b10, 0, 0, 0); expect0("t3_l5", 8'h1A, 5, 8'h4D, 0);
        step0(0, 1, 2'b10, 0, 0, 0); expect0("t3_l6", 8'h34, 6, 8'h4D, 0);
        step0(0, 1, 2'b10, 0, 0, 0); expect0("t3_l7", 8'h68, 7, 8'h4D, 0);
        step0(0, 1, 2'b10, 0, 0, 0); expect0("t3_l8", 8'hD0, 0, 8'hD0, 1);

        // 4. Parallel load then one right shift
        step0(0, 1, 2'b11, 0, 0, 8'hA5); expect0("t4_load", 8'hA5, 0, 8'hD0, 0);
        step0(0, 1, 2'b01, 0, 0, 0);     expect0("t4_shift", 8'h52, 1, 8'hD0, 0);

        // 5. Enable gating, then sclr over a load
        for (int i = 0; i < 5; i++) begin
            step0(0, 0, 2'b01, 1, 1, 0);
            expect0($sformatf("t5_gate%0d", i), 8'h52, 1, 8'hD0, 0);
        end
        step0(1, 1, 2'b11, 0, 0, 8'hFF); expect0("t5_sclr_prio", 8'h00, 0, 8'hD0, 0);

        // Direction change mid-word keeps counting lanes
        for (int i = 0; i < 8; i++) begin
            step0(0, 1, (i < 4) ? 2'b01 : 2'b10, 1, 0, 0);
            expect0($sformatf("t5_mix%0d", i + 1), mq[i], (i + 1) % 8,
                    (i == 7) ? 8'h00 : 8'hD0, i == 7);
        end

        // 6. Wide lanes on DUT 1, back-to-back words
        step1(1, 2'b01, 4'h3); expect1("t6_s1", 8'h30, 1, 8'h00, 0);
        step1(1, 2'b01, 4'hC); expect1("t6_s2", 8'hC3, 0, 8'hC3, 1);
        step1(1, 2'b01, 4'h5); expect1("t6_s3", 8'h5C, 1, 8'hC3, 0);
        step1(1, 2'b01, 4'hA); expect1("t6_s4", 8'hA5, 0, 8'hA5, 1);
        step1(0, 2'b01, 4'hF); expect1("t6_hold", 8'hA5, 0, 8'hA5, 0);

        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register. It generalises the fixed 4-bit serial-in/parallel-out chain to WIDTH bits and LANE_W bits per shift, and adds four modes: hold, shift right, shift left and parallel load. A word counter captures each completely shifted-in word into a snapshot register and flags it with a one-cycle strobe. It is the common deserialiser/serialiser primitive for the shift-register library.

Parameters:
WIDTH, 8, register width in bits; must be ≥ 2 and an integer multiple of LANE_W.
LANE_W, 1, bits shifted per enabled shift cycle (serial lane width); 1 ≤ LANE_W ≤ WIDTH.
CNT_W, max(1, clog2(WIDTH/LANE_W)), derived localparam giving the width of cnt; not overridable.

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
en  input  1  shift/load enable; when low the block holds.
sclr  input  1  synchronous clear; has priority over en.
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
sin_r  input  LANE_W  serial input for shift right; enters at the MSB end.
sin_l  input  LANE_W  serial input for shift left; enters at the LSB end.
pin  input  WIDTH  parallel load data.
q  output  WIDTH  register contents.
sout_r  output  LANE_W  q[LANE_W-1:0], the lane leaving on a right shift.
sout_l  output  LANE_W  q[WIDTH-1 -: LANE_W], the lane leaving on a left shift.
cnt  output  CNT_W  number of lanes shifted in for the current word.
word_q  output  WIDTH  snapshot of the last completed word.
word_valid  output  1  one-cycle strobe marking a new word_q.

Behaviour:
- Reset (reset_n=0, asynchronous, at any time including mid-word): q, cnt, word_q = 0 and word_valid = 0 immediately. All remain at 0 until the first rising edge after reset_n deasserts.
- All other updates occur on the rising edge of clk. Priority order: sclr, then en, then mode.
- sclr=1: q←0, cnt←0, word_valid←0. word_q is retained.
- en=0 (and sclr=0): q, cnt and word_q hold; word_valid←0.
- en=1, mode=00: hold; word_valid←0.
- en=1, mode=01: q←{sin_r, q[WIDTH-1:LANE_W]}.
- en=1, mode=10: q←{q[WIDTH-LANE_W-1:0], sin_l}.
- en=1, mode=11: q←pin, cnt←0, word_valid←0.
- Shift word counting. Let N = WIDTH/LANE_W.
  - Each enabled shift (mode 01 or 10) increments cnt.
  - On the shift where cnt==N-1: cnt←0, word_q←the new q value (the post-shift value, not the old q), and word_valid←1 in that same edge.
  - word_valid is therefore high for exactly the one cycle after the completing shift. It is low on every other edge.
  - Back-to-back words produce a strobe every N enabled shifts with no gap cycle.
- A direction change mid-word does not reset cnt; the lanes are counted regardless of direction.
- N=1 (LANE_W=WIDTH): every enabled shift completes a word, and cnt stays 0.
- sout_r and sout_l are combinational slices of q; they are valid in the same cycle as q.
- Latency: q updates one edge after a sampled command. word_q and word_valid update on the same edge as the completing q.

Test Plan:
1. Reset mid-operation. WIDTH=8, LANE_W=1: shift three bits, then pulse reset_n low between edges → q=0x00, cnt=0, word_q=0x00, word_valid=0 immediately without a clock edge; operation restarts cleanly after release.
2. Shift right. en=1, mode=01, sin_r=1,0,1,1,0,0,1,0 on 8 edges → q=0x4D after the 8th edge, word_q=0x4D, word_valid=1 for exactly one cycle, cnt=0. cnt reads 1..7 after edges 1..7.
3. Shift left. sclr once, then mode=10, sin_l=1,1,0,1 → q=0x0D, cnt=4, word_valid=0. Four further shifts of 0 → q=0xD0, word_valid pulses, word_q=0xD0.
4. Load, then shift. mode=11, pin=0xA5 → q=0xA5, cnt=0, sout_r=1, sout_l=1. Then mode=01, sin_r=0 → q=0x52, sout_r=0, cnt=1.
5. Gating and priority. en=0 with mode=01 for 5 edges → q and cnt unchanged, word_valid=0. sclr=1 with en=1, mode=11, pin=0xFF → q=0x00 and cnt=0, with word_q unchanged.
6. Wide lanes. WIDTH=8, LANE_W=4, mode=01, sin_r=0x3 then 0xC → q=0xC3, word_valid after the 2nd shift, word_q=0xC3. Continuing with 0x5 and 0xA → second strobe exactly two edges later, word_q=0xA5.
